// File: rtl/ann_pkg.sv
// Shared constants, layer encodings, FSM states and sizing helpers for the
// ANN memory read path.
package ann_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      result = result + (((32'sd1 <<< i) < value) ? 32'sd1 : 32'sd0);
    end
    return result;
  endfunction

  localparam int DATA_COUNTER_WIDTH   = clog2(32);
  localparam int WEIGHT_COUNTER_WIDTH = 11;
  localparam int DIM_W                = DATA_COUNTER_WIDTH + 1;

  localparam logic [1:0] LAYER_H1  = 2'd1;
  localparam logic [1:0] LAYER_H2  = 2'd2;
  localparam logic [1:0] LAYER_OUT = 2'd3;

  localparam logic [DIM_W-1:0] DIM_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } reader_state_e;

  typedef struct packed {
    logic [DIM_W-1:0] fan_in;
    logic [DIM_W-1:0] nodes;
  } layer_dims_t;

  // Fan-in and node count of a layer; an unused encoding gets a harmless 1x1.
  function automatic layer_dims_t layer_dims(input logic [1:0] layer,
                                             input int n_in, input int h1,
                                             input int h2, input int n_out);
    layer_dims_t d;
    case (layer)
      LAYER_H1: begin
        d.fan_in = DIM_W'(n_in);
        d.nodes  = DIM_W'(h1);
      end
      LAYER_H2: begin
        d.fan_in = DIM_W'(h1);
        d.nodes  = DIM_W'(h2);
      end
      LAYER_OUT: begin
        d.fan_in = DIM_W'(h2);
        d.nodes  = DIM_W'(n_out);
      end
      default: begin
        d.fan_in = DIM_ONE;
        d.nodes  = DIM_ONE;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ann_pair_tracker.sv
// Return-side bookkeeping: mirrors the issue counters, checks every returned
// beat against the expected address/layer and classifies it as pair or error.
module ann_pair_tracker
  import ann_pkg::*;
#(
  parameter int LAYER_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_clear,
  input  logic                            i_enable,
  input  logic [DIM_W-1:0]                i_fan_in,
  input  logic [DIM_W-1:0]                i_nodes,
  input  logic [LAYER_WIDTH-1:0]          i_exp_data_layer,
  input  logic [LAYER_WIDTH-1:0]          i_exp_weight_layer,
  input  logic                            i_data_valid,
  input  logic [LAYER_WIDTH-1:0]          i_data_layer,
  input  logic [DATA_COUNTER_WIDTH-1:0]   i_data_addr,
  input  logic                            i_weight_valid,
  input  logic [LAYER_WIDTH-1:0]          i_weight_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr,
  output logic                            o_accept,
  output logic                            o_mismatch,
  output logic [DATA_COUNTER_WIDTH-1:0]   o_node_idx,
  output logic                            o_last_input,
  output logic                            o_last
);

  localparam logic [DATA_COUNTER_WIDTH-1:0]   CNT_ZERO  = {DATA_COUNTER_WIDTH{1'b0}};
  localparam logic [DATA_COUNTER_WIDTH-1:0]   CNT_ONE   = {{(DATA_COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] WADDR_ONE = {{(WEIGHT_COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_COUNTER_WIDTH-1:0]   idx_q, idx_d, node_q, node_d;
  logic [WEIGHT_COUNTER_WIDTH-1:0] waddr_q, waddr_d;
  logic beat, match, last_input, last_node;

  // Beat classification and expected-address advance. Any beat, good or bad,
  // consumes one expected slot so later beats stay aligned with their requests.
  always_comb begin
    beat       = i_enable && (i_data_valid || i_weight_valid);
    match      = i_data_valid && i_weight_valid &&
                 (i_data_layer == i_exp_data_layer) &&
                 (i_weight_layer == i_exp_weight_layer) &&
                 (i_data_addr == idx_q) && (i_weight_addr == waddr_q);
    last_input = ({1'b0, idx_q} == (i_fan_in - DIM_ONE));
    last_node  = ({1'b0, node_q} == (i_nodes - DIM_ONE));
    o_accept     = beat && match;
    o_mismatch   = beat && !match;
    o_node_idx   = node_q;
    o_last_input = last_input;
    o_last       = last_input && last_node;
    idx_d   = idx_q;
    node_d  = node_q;
    waddr_d = waddr_q;
    if (i_clear) begin
      idx_d   = CNT_ZERO;
      node_d  = CNT_ZERO;
      waddr_d = {WEIGHT_COUNTER_WIDTH{1'b0}};
    end else if (beat) begin
      waddr_d = waddr_q + WADDR_ONE;
      if (last_input) begin
        idx_d  = CNT_ZERO;
        node_d = node_q + CNT_ONE;
      end else begin
        idx_d  = idx_q + CNT_ONE;
        node_d = node_q;
      end
    end else begin
      waddr_d = waddr_q;
    end
  end

  // Expected-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= CNT_ZERO;
      node_q  <= CNT_ZERO;
      waddr_q <= {WEIGHT_COUNTER_WIDTH{1'b0}};
    end else begin
      idx_q   <= idx_d;
      node_q  <= node_d;
      waddr_q <= waddr_d;
    end
  end

endmodule

// File: rtl/ann_memory_reader.sv
// Read initiator for one ANN layer: issues matched data/weight RAM reads for
// every (node, input) pair and streams the paired operands to the MAC path.
module ann_memory_reader
  import ann_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic [LAYER_WIDTH-1:0]          i_layer,
  output logic                            o_ram_data_enable,
  output logic                            o_rw_data_select,
  output logic [LAYER_WIDTH-1:0]          o_data_layer,
  output logic [DATA_COUNTER_WIDTH-1:0]   o_data_addr,
  output logic                            o_ram_weight_enable,
  output logic                            o_rw_weight_select,
  output logic [LAYER_WIDTH-1:0]          o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
  input  logic                            i_data_valid,
  input  logic [LAYER_WIDTH-1:0]          i_data_layer,
  input  logic [DATA_COUNTER_WIDTH-1:0]   i_data_addr,
  input  logic [DATA_WIDTH-1:0]           i_data,
  input  logic                            i_weight_valid,
  input  logic [LAYER_WIDTH-1:0]          i_weight_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr,
  input  logic [DATA_WIDTH-1:0]           i_weight,
  output logic                            o_pair_valid,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [DATA_WIDTH-1:0]           o_weight,
  output logic [DATA_COUNTER_WIDTH-1:0]   o_node_idx,
  output logic                            o_last_input,
  output logic                            o_last,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error
);

  localparam int OW = WEIGHT_COUNTER_WIDTH + 1;
  localparam logic [LAYER_WIDTH-1:0]          LAYER_ZERO = {LAYER_WIDTH{1'b0}};
  localparam logic [LAYER_WIDTH-1:0]          LAYER_ONE  = {{(LAYER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_COUNTER_WIDTH-1:0]   CNT_ZERO   = {DATA_COUNTER_WIDTH{1'b0}};
  localparam logic [DATA_COUNTER_WIDTH-1:0]   CNT_ONE    = {{(DATA_COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] WADDR_ZERO = {WEIGHT_COUNTER_WIDTH{1'b0}};
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] WADDR_ONE  = {{(WEIGHT_COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0]                   OUT_ZERO   = {OW{1'b0}};
  localparam logic [OW-1:0]                   OUT_ONE    = {{(OW-1){1'b0}}, 1'b1};

  reader_state_e                   state_q, state_d;
  logic [LAYER_WIDTH-1:0]          layer_q, layer_d, data_layer_q, data_layer_d;
  logic [DATA_COUNTER_WIDTH-1:0]   idx_q, idx_d, node_q, node_d, node_idx_q, node_idx_d;
  logic [WEIGHT_COUNTER_WIDTH-1:0] waddr_q, waddr_d;
  logic [OW-1:0]                   outst_q, outst_d;
  logic en_q, en_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic pair_valid_q, pair_valid_d, last_input_q, last_input_d, last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, weight_q, weight_d;

  layer_dims_t dims;
  logic start_ok, pair_enable, last_col, last_issue;
  logic trk_accept, trk_mismatch, trk_last_input, trk_last;
  logic [DATA_COUNTER_WIDTH-1:0] trk_node;

  assign dims = layer_dims(layer_q[1:0], NUMBER_OF_INPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_1,
                           NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE);
  assign start_ok    = (state_q == S_IDLE) && i_start && (i_layer != LAYER_ZERO);
  assign pair_enable = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign last_col    = ({1'b0, idx_q} == (dims.fan_in - DIM_ONE));
  assign last_issue  = last_col && ({1'b0, node_q} == (dims.nodes - DIM_ONE));

  ann_pair_tracker #(.LAYER_WIDTH(LAYER_WIDTH)) u_tracker (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_clear            (start_ok),
    .i_enable           (pair_enable),
    .i_fan_in           (dims.fan_in),
    .i_nodes            (dims.nodes),
    .i_exp_data_layer   (data_layer_q),
    .i_exp_weight_layer (layer_q),
    .i_data_valid       (i_data_valid),
    .i_data_layer       (i_data_layer),
    .i_data_addr        (i_data_addr),
    .i_weight_valid     (i_weight_valid),
    .i_weight_layer     (i_weight_layer),
    .i_weight_addr      (i_weight_addr),
    .o_accept           (trk_accept),
    .o_mismatch         (trk_mismatch),
    .o_node_idx         (trk_node),
    .o_last_input       (trk_last_input),
    .o_last             (trk_last)
  );

  // Next-state, request counters, outstanding count and pair capture.
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    data_layer_d = data_layer_q;
    idx_d        = idx_q;
    node_d       = node_q;
    waddr_d      = waddr_q;
    en_d         = en_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q || trk_mismatch;
    outst_d      = outst_q + (en_q ? OUT_ONE : OUT_ZERO)
                           - ((trk_accept || trk_mismatch) ? OUT_ONE : OUT_ZERO);
    pair_valid_d = trk_accept;
    data_d       = trk_accept ? i_data : data_q;
    weight_d     = trk_accept ? i_weight : weight_q;
    node_idx_d   = trk_accept ? trk_node : node_idx_q;
    last_input_d = trk_accept && trk_last_input;
    last_d       = trk_accept && trk_last;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d      = S_ISSUE;
          layer_d      = i_layer;
          data_layer_d = i_layer - LAYER_ONE;
          idx_d        = CNT_ZERO;
          node_d       = CNT_ZERO;
          waddr_d      = WADDR_ZERO;
          outst_d      = OUT_ZERO;
          en_d         = 1'b1;
          busy_d       = 1'b1;
          error_d      = 1'b0;
        end else if (i_start) begin
          error_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        waddr_d = waddr_q + WADDR_ONE;
        if (last_col) begin
          idx_d  = CNT_ZERO;
          node_d = node_q + CNT_ONE;
        end else begin
          idx_d  = idx_q + CNT_ONE;
          node_d = node_q;
        end
        if (last_issue) begin
          state_d = S_DRAIN;
          en_d    = 1'b0;
        end else begin
          state_d = S_ISSUE;
          en_d    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (outst_q == OUT_ZERO) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any layer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      layer_q      <= LAYER_ZERO;
      data_layer_q <= LAYER_ZERO;
      idx_q        <= CNT_ZERO;
      node_q       <= CNT_ZERO;
      waddr_q      <= WADDR_ZERO;
      outst_q      <= OUT_ZERO;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      pair_valid_q <= 1'b0;
      data_q       <= {DATA_WIDTH{1'b0}};
      weight_q     <= {DATA_WIDTH{1'b0}};
      node_idx_q   <= CNT_ZERO;
      last_input_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      data_layer_q <= data_layer_d;
      idx_q        <= idx_d;
      node_q       <= node_d;
      waddr_q      <= waddr_d;
      outst_q      <= outst_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      pair_valid_q <= pair_valid_d;
      data_q       <= data_d;
      weight_q     <= weight_d;
      node_idx_q   <= node_idx_d;
      last_input_q <= last_input_d;
      last_q       <= last_d;
    end
  end

  assign o_ram_data_enable   = en_q;
  assign o_ram_weight_enable = en_q;
  assign o_rw_data_select    = 1'b1;
  assign o_rw_weight_select  = 1'b1;
  assign o_data_layer        = data_layer_q;
  assign o_weight_layer      = layer_q;
  assign o_data_addr         = idx_q;
  assign o_weight_addr       = waddr_q;
  assign o_pair_valid        = pair_valid_q;
  assign o_data              = data_q;
  assign o_weight            = weight_q;
  assign o_node_idx          = node_idx_q;
  assign o_last_input        = last_input_q;
  assign o_last              = last_q;
  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_error             = error_q;

endmodule

// File: tb/tb_ann_memory_reader.sv
// Directed bench for ann_memory_reader with random RAM contents, a 1-cycle
// RAM model and a per-layer expected request/pair list built from the layer table.
module tb_ann_memory_reader;

  logic clk = 1'b0;
  logic rst_n;
  logic i_start;
  logic [1:0] i_layer;
  logic o_ram_data_enable, o_rw_data_select, o_ram_weight_enable, o_rw_weight_select;
  logic [1:0] o_data_layer, o_weight_layer;
  logic [4:0] o_data_addr;
  logic [10:0] o_weight_addr;
  logic i_data_valid, i_weight_valid;
  logic [1:0] i_data_layer, i_weight_layer;
  logic [4:0] i_data_addr;
  logic [10:0] i_weight_addr;
  logic [31:0] i_data, i_weight;
  logic o_pair_valid, o_last_input, o_last, o_busy, o_done, o_error;
  logic [31:0] o_data, o_weight;
  logic [4:0] o_node_idx;

  always #5 clk = ~clk;

  ann_memory_reader dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_layer(i_layer),
    .o_ram_data_enable(o_ram_data_enable), .o_rw_data_select(o_rw_data_select),
    .o_data_layer(o_data_layer), .o_data_addr(o_data_addr),
    .o_ram_weight_enable(o_ram_weight_enable), .o_rw_weight_select(o_rw_weight_select),
    .o_weight_layer(o_weight_layer), .o_weight_addr(o_weight_addr),
    .i_data_valid(i_data_valid), .i_data_layer(i_data_layer), .i_data_addr(i_data_addr), .i_data(i_data),
    .i_weight_valid(i_weight_valid), .i_weight_layer(i_weight_layer), .i_weight_addr(i_weight_addr),
    .i_weight(i_weight), .o_pair_valid(o_pair_valid), .o_data(o_data), .o_weight(o_weight),
    .o_node_idx(o_node_idx), .o_last_input(o_last_input), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  typedef struct { int dl; int wl; int da; int wa; } req_t;
  typedef struct { logic [31:0] d; logic [31:0] w; int node; logic li; logic last; } pair_t;

  req_t  exp_req[$];
  pair_t exp_pair[$];
  logic [31:0] data_mem [4][32];
  logic [31:0] weight_mem [4][1024];

  int tests = 0, fails = 0;
  int cyc = 0, req_cnt = 0, pair_cnt = 0, li_cnt = 0, last_cnt = 0, done_cnt = 0;
  int last_cyc = 0, done_cyc = 0, beat_idx = 0, drop_beat = -1;
  int exp_li = 0, exp_last = 0, exp_pairs = 0;
  logic busy_at_done = 1'b0;
  logic pend_v = 1'b0;
  logic [1:0] pend_dl = 2'd0, pend_wl = 2'd0;
  logic [4:0] pend_da = 5'd0;
  logic [10:0] pend_wa = 11'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int fan_of(input int layer);
    return (layer == 1) ? 2 : 32;
  endfunction

  function automatic int nodes_of(input int layer);
    return (layer == 3) ? 3 : 32;
  endfunction

  // Expected traffic for a layer: node-major walk, one pair per (node, input).
  task automatic build(input int layer, input int drop);
    int fan, nodes, b;
    fan = fan_of(layer); nodes = nodes_of(layer); b = 0;
    exp_req.delete(); exp_pair.delete();
    exp_li = 0; exp_last = 0;
    for (int n = 0; n < nodes; n++) begin
      for (int i = 0; i < fan; i++) begin
        pair_t p;
        exp_req.push_back('{layer - 1, layer, i, n * fan + i});
        p.d = data_mem[layer - 1][i]; p.w = weight_mem[layer][n * fan + i];
        p.node = n; p.li = (i == fan - 1); p.last = (i == fan - 1) && (n == nodes - 1);
        if (b != drop) begin
          exp_pair.push_back(p);
          exp_li += p.li ? 1 : 0;
          exp_last += p.last ? 1 : 0;
        end
        b++;
      end
    end
    exp_pairs = exp_pair.size();
  endtask

  // One clock: deliver last cycle's requests as returns, then observe outputs.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    i_data_valid   = pend_v;
    i_weight_valid = pend_v && (beat_idx != drop_beat);
    i_data_layer   = pend_dl; i_data_addr   = pend_da; i_data   = data_mem[pend_dl][pend_da];
    i_weight_layer = pend_wl; i_weight_addr = pend_wa; i_weight = weight_mem[pend_wl][pend_wa];
    if (pend_v) beat_idx++;
    pend_v = o_ram_data_enable;
    pend_dl = o_data_layer; pend_da = o_data_addr; pend_wl = o_weight_layer; pend_wa = o_weight_addr;
    if (o_ram_data_enable || o_ram_weight_enable) begin
      req_cnt++;
      chk("req_den", o_ram_data_enable, 1);
      chk("req_wen", o_ram_weight_enable, 1);
      if (exp_req.size() == 0) chk("req_extra", 1, 0);
      else begin
        req_t r;
        r = exp_req.pop_front();
        chk("req_dlayer", o_data_layer, r.dl);
        chk("req_wlayer", o_weight_layer, r.wl);
        chk("req_daddr", o_data_addr, r.da);
        chk("req_waddr", o_weight_addr, r.wa);
      end
    end
    if (o_pair_valid) begin
      pair_cnt++;
      if (exp_pair.size() == 0) chk("pair_extra", 1, 0);
      else begin
        pair_t p;
        p = exp_pair.pop_front();
        chk("pair_data", o_data, p.d);
        chk("pair_weight", o_weight, p.w);
        chk("pair_node", o_node_idx, p.node);
        chk("pair_last_input", o_last_input, p.li);
        chk("pair_last", o_last, p.last);
      end
    end
    if (o_last_input) li_cnt++;
    if (o_last) begin last_cnt++; last_cyc = cyc; end
    if (o_done) begin done_cnt++; done_cyc = cyc; busy_at_done = o_busy; end
  endtask

  task automatic run_layer(input int layer, input int drop, input int restart_at, input logic exp_err);
    int r0, p0, l0, la0, d0;
    build(layer, drop);
    drop_beat = drop; beat_idx = 0;
    r0 = req_cnt; p0 = pair_cnt; l0 = li_cnt; la0 = last_cnt; d0 = done_cnt;
    i_layer = 2'(layer); i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_err_clear", o_error, 0);
    for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
      if (restart_at >= 0 && req_cnt - r0 == restart_at) begin
        i_layer = 2'd2; i_start = 1'b1;
        tick();
        i_start = 1'b0;
      end else tick();
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("busy_at_done", busy_at_done, 0);
    chk("done_after_last", done_cyc - last_cyc, 1);
    for (int k = 0; k < 3; k++) tick();
    chk("done_once", done_cnt - d0, 1);
    chk("req_count", req_cnt - r0, fan_of(layer) * nodes_of(layer));
    chk("pair_count", pair_cnt - p0, exp_pairs);
    chk("last_input_count", li_cnt - l0, exp_li);
    chk("last_count", last_cnt - la0, exp_last);
    chk("pairs_left", exp_pair.size(), 0);
    chk("error_end", o_error, exp_err);
    chk("busy_end", o_busy, 0);
  endtask

  initial begin
    int r0;
    for (int l = 0; l < 4; l++) begin
      for (int a = 0; a < 32; a++) data_mem[l][a] = $urandom;
      for (int a = 0; a < 1024; a++) weight_mem[l][a] = $urandom;
    end
    rst_n = 1'b0; i_start = 1'b0; i_layer = 2'd0;
    i_data_valid = 1'b0; i_weight_valid = 1'b0; i_data_layer = 2'd0; i_weight_layer = 2'd0;
    i_data_addr = 5'd0; i_weight_addr = 11'd0; i_data = 32'd0; i_weight = 32'd0;
    tick(); tick();
    chk("rst_den", o_ram_data_enable, 0);
    chk("rst_wen", o_ram_weight_enable, 0);
    chk("rst_rw_data", o_rw_data_select, 1);
    chk("rst_rw_weight", o_rw_weight_select, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_pair_valid", o_pair_valid, 0);
    chk("rst_waddr", o_weight_addr, 0);
    rst_n = 1'b1;
    tick();

    run_layer(1, -1, -1, 1'b0);
    run_layer(3, -1, -1, 1'b0);

    r0 = req_cnt;
    i_layer = 2'd0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("bad_layer_error", o_error, 1);
    chk("bad_layer_busy", o_busy, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("bad_layer_no_req", req_cnt - r0, 0);
    chk("bad_layer_sticky", o_error, 1);

    run_layer(1, 10, -1, 1'b1);

    build(2, -1);
    drop_beat = -1; beat_idx = 0; r0 = req_cnt;
    i_layer = 2'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 200 && req_cnt - r0 < 20; k++) tick();
    chk("abort_reached", req_cnt - r0, 20);
    rst_n = 1'b0;
    tick();
    chk("abort_pair_valid", o_pair_valid, 0);
    chk("abort_den", o_ram_data_enable, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_wlayer", o_weight_layer, 0);
    chk("abort_dlayer", o_data_layer, 0);
    chk("abort_daddr", o_data_addr, 0);
    tick();
    chk("abort_pair_valid2", o_pair_valid, 0);
    chk("abort_done", o_done, 0);
    rst_n = 1'b1;
    tick();

    run_layer(1, -1, int'($urandom_range(5, 50)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ann_memory_reader.md
Name: ann_memory_reader

Overview:
- Read initiator for the ANN memory block: on a start command for layer k, walks every (node, input) pair of that layer. Issues matched reads to the data RAM (source activations, layer k-1) and the weight RAM (layer k).
- Pairs the returned activation and weight, then streams them to the neuron MAC datapath with node/input indices and end-of-node / end-of-layer markers.
- Sits between the layer controller and the data and weight RAMs in the forward-pass path.

Parameters:
- DATA_WIDTH, 32, width of activations and weights.
- LAYER_WIDTH, 2, width of layer selects.
- NUMBER_OF_INPUT_NODE, 2, fan-in of layer 1.
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, nodes in layer 1 and fan-in of layer 2.
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, nodes in layer 2 and fan-in of layer 3.
- NUMBER_OF_OUTPUT_NODE, 3, nodes in layer 3.
- Local constant DATA_COUNTER_WIDTH = clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1).
- Local constant WEIGHT_COUNTER_WIDTH = 11.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse; accepted only in IDLE
- i_layer  in  LAYER_WIDTH  target layer, legal values 1..3
- o_ram_data_enable  out  1  data RAM request strobe
- o_rw_data_select  out  1  tied to 1 (read)
- o_data_layer  out  LAYER_WIDTH  request layer = i_layer-1
- o_data_addr  out  DATA_COUNTER_WIDTH  input index
- o_ram_weight_enable  out  1  weight RAM request strobe
- o_rw_weight_select  out  1  tied to 1 (read)
- o_weight_layer  out  LAYER_WIDTH  request layer = i_layer
- o_weight_addr  out  WEIGHT_COUNTER_WIDTH  node*fan_in + input index
- i_data_valid, i_data_layer, i_data_addr, i_data  in  1/LAYER_WIDTH/DATA_COUNTER_WIDTH/DATA_WIDTH  data RAM return
- i_weight_valid, i_weight_layer, i_weight_addr, i_weight  in  1/LAYER_WIDTH/WEIGHT_COUNTER_WIDTH/DATA_WIDTH  weight RAM return
- o_pair_valid  out  1  paired operand strobe
- o_data, o_weight  out  DATA_WIDTH each  paired operands
- o_node_idx  out  DATA_COUNTER_WIDTH  node index of the pair
- o_last_input  out  1  last input of current node
- o_last  out  1  last pair of layer
- o_busy  out  1  high from start acceptance until done
- o_done  out  1  one-cycle pulse after the final pair
- o_error  out  1  sticky until next accepted start; illegal layer or return mismatch

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation aborts immediately. Returns arriving after reset are ignored because pairing is enabled only in ISSUE/DRAIN.
- Fan-in/nodes by layer:
  - layer 1: NUMBER_OF_INPUT_NODE / H1
  - layer 2: H1 / H2
  - layer 3: H2 / NUMBER_OF_OUTPUT_NODE
- States:
  - IDLE: i_start with layer 1..3 latches the layer, clears o_error and counters, moves to ISSUE. i_start with layer 0 sets o_error and stays in IDLE.
  - ISSUE: one request per cycle on both RAMs simultaneously, enables high. The input index increments, wrapping at fan_in-1; the node index increments on wrap. The weight address increments linearly. After the request for (nodes-1, fan_in-1), go to DRAIN.
  - DRAIN: enables low; wait until the outstanding count reaches 0.
  - DONE: o_done=1 for one cycle, o_busy=0, go to IDLE.
- i_start outside IDLE is ignored.
- Outstanding counter: +1 per issued request, -1 per accepted pair, simultaneous +1/-1 leaves it unchanged. Width is WEIGHT_COUNTER_WIDTH+1.
- Pairing:
  - Both returns are required in the same cycle, since the RAMs share fixed latency.
  - o_pair_valid is registered, 1 cycle after the returns.
  - o_data and o_weight are captured from the return buses.
  - o_node_idx and o_last_input come from a return-side counter pair mirroring the issue counters.
  - o_last = last_input AND node == nodes-1.
- Mismatch: exactly one valid, or a returned address/layer different from the return-side expected value. Sets o_error, drops that beat, and decrements outstanding so the block still terminates.
- Width rule: weight address = node*fan_in + idx, computed incrementally (no multiplier). Maximum 32*32-1 = 1023 fits in 11 bits.

Decomposition:
- Shared package ann_pkg:
  - layer encodings LAYER_H1=1, LAYER_H2=2, LAYER_OUT=3
  - the DATA/WEIGHT_COUNTER_WIDTH constants
  - clog2 function
  - fan-in/node-count lookup function
- One natural sub-module, ann_pair_tracker: return-side expected-address counters plus mismatch check, instantiated once.

Test Plan:
- Reset asserted, then start layer 1: 64 requests on consecutive cycles, weight addr 0..63, data addr alternating 0,1. Model RAM (1-cycle latency) -> 64 pairs, o_last_input on every 2nd pair, o_last on pair 63, o_done 1 cycle after.
- Start layer 3: 96 requests, data layer=2, weight layer=3, node_idx 0..2. o_last_input at idx 31 -> o_done once; o_busy low in the same cycle as o_done.
- Start with i_layer=0 -> o_error=1, no enable toggles. A subsequent valid start clears o_error.
- Model drops i_weight_valid on beat 10 of layer 1 -> o_error=1, 63 pairs output, o_done still fires.
- rst_n low at request 20 of layer 2, late returns continue 1 cycle -> o_pair_valid stays 0, all outputs 0. A new start then proceeds cleanly from addr 0.
- i_start pulsed again during ISSUE -> ignored, request count unchanged.
